// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
// Shared definitions for the memory responder slice: the word width used by
// the CPU datapath, the wait-counter width and the one-hot FSM encoding.
package mem_responder_pkg;

  // Word width matches the instruction width used by the control unit.
  localparam int MEM_WORD_WIDTH = 16;

  // Wait counter covers the legal WAIT_CYCLES range 0..15.
  localparam int CNT_WIDTH = 4;

  // One-hot, 4-bit state encoding.
  typedef enum logic [3:0] {
    ST_INIT = 4'b0001,
    ST_IDLE = 4'b0010,
    ST_BUSY = 4'b0100,
    ST_DONE = 4'b1000
  } state_t;

endpackage

// File: rtl/mem_responder_mem_array.sv
// mem_array
// Single-port synchronous RAM, 2**ADDR_WIDTH words of MEM_WORD_WIDTH bits,
// with a registered read port. Contents are never reset.
// Ports:
//   i_clk    clock
//   i_we     write enable, writes i_wdata to i_addr on the rising edge
//   i_re     read enable, loads o_rdata from i_addr on the rising edge
//   i_addr   word address
//   i_wdata  write data
//   o_rdata  registered read data, held while i_re is low
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_we,
  input  logic                      i_re,
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  input  logic [MEM_WORD_WIDTH-1:0] i_wdata,
  output logic [MEM_WORD_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [MEM_WORD_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [MEM_WORD_WIDTH-1:0] r_rdata;

  // Storage has no reset so it maps onto plain RAM blocks.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// mem_responder
// Memory-side responder for the CPU's single-outstanding memory handshake.
// Accepts one read or write while idle, waits WAIT_CYCLES extra cycles,
// then completes against the internal word array and signals completion.
// Ports:
//   I_clk         clock, all state changes on the rising edge
//   I_reset_n     asynchronous active-low reset
//   I_execute     request strobe, honoured only while O_mem_ready=1
//   I_we          1 = write, 0 = read (sampled with I_execute)
//   I_addr        word address (sampled with I_execute)
//   I_data        write data (sampled with I_execute)
//   O_data        read data, updated only when a read completes
//   O_mem_ready   1 = idle and able to accept a request
//   O_data_ready  one-cycle pulse marking read completion
//   O_overrun     sticky flag: a request arrived while busy
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                      I_clk,
  input  logic                      I_reset_n,
  input  logic                      I_execute,
  input  logic                      I_we,
  input  logic [ADDR_WIDTH-1:0]     I_addr,
  input  logic [MEM_WORD_WIDTH-1:0] I_data,
  output logic [MEM_WORD_WIDTH-1:0] O_data,
  output logic                      O_mem_ready,
  output logic                      O_data_ready,
  output logic                      O_overrun
);

  localparam logic [CNT_WIDTH-1:0] LP_WAIT = CNT_WIDTH'(WAIT_CYCLES);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [CNT_WIDTH-1:0]      r_cnt;
  logic [CNT_WIDTH-1:0]      w_cnt_nxt;
  logic                      r_we;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [MEM_WORD_WIDTH-1:0] r_wdata;
  logic [MEM_WORD_WIDTH-1:0] r_data;
  logic                      r_mem_ready;
  logic                      r_data_ready;
  logic                      r_overrun;

  logic                      w_accept;
  logic                      w_mem_ready_nxt;
  logic                      w_overrun_nxt;
  logic                      w_ram_we;
  logic                      w_ram_re;
  logic                      w_load_data;
  logic [MEM_WORD_WIDTH-1:0] w_ram_rdata;

  mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem_array (
    .i_clk  (I_clk),
    .i_we   (w_ram_we),
    .i_re   (w_ram_re),
    .i_addr (r_addr),
    .i_wdata(r_wdata),
    .o_rdata(w_ram_rdata)
  );

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_accept        = 1'b0;
    w_mem_ready_nxt = r_mem_ready;
    w_overrun_nxt   = r_overrun;
    w_ram_we        = 1'b0;
    w_ram_re        = 1'b0;
    w_load_data     = 1'b0;

    case (r_state)
      ST_INIT: begin
        w_state_nxt     = ST_IDLE;
        w_mem_ready_nxt = 1'b1;
      end
      ST_IDLE: begin
        if (I_execute) begin
          w_accept        = 1'b1;
          w_mem_ready_nxt = 1'b0;
          w_cnt_nxt       = LP_WAIT;
          w_state_nxt     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_state_nxt = ST_DONE;
          // The RAM read is registered, so issue it one cycle before DONE
          // to have the word ready when DONE completes the read.
          w_ram_re    = ~r_we;
        end
      end
      ST_DONE: begin
        w_state_nxt     = ST_IDLE;
        w_mem_ready_nxt = 1'b1;
        if (r_we) begin
          w_ram_we = 1'b1;
        end else begin
          w_load_data = 1'b1;
        end
      end
      default: begin
        w_state_nxt     = ST_INIT;
        w_mem_ready_nxt = 1'b0;
      end
    endcase

    // A strobe while an operation is in flight is dropped but remembered.
    if (I_execute && ((r_state == ST_BUSY) || (r_state == ST_DONE))) begin
      w_overrun_nxt = 1'b1;
    end
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_data       <= '0;
      r_mem_ready  <= 1'b0;
      r_data_ready <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_mem_ready  <= w_mem_ready_nxt;
      r_overrun    <= w_overrun_nxt;
      r_data_ready <= w_load_data;
      if (w_accept) begin
        r_we    <= I_we;
        r_addr  <= I_addr;
        r_wdata <= I_data;
      end
      if (w_load_data) begin
        r_data <= w_ram_rdata;
      end
    end
  end

  assign O_data       = r_data;
  assign O_mem_ready  = r_mem_ready;
  assign O_data_ready = r_data_ready;
  assign O_overrun    = r_overrun;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
// Drives two responders side by side (WAIT_CYCLES=2 and WAIT_CYCLES=0).
// Reads push their expected word and completion edge into a per-instance
// scoreboard; a negedge monitor pops and compares on every O_data_ready.
module tb_mem_responder;

  localparam int AW     = 8;
  localparam int WAIT_A = 2;
  localparam int WAIT_B = 0;

  typedef struct {
    logic [15:0] data;
    int          edgeNum;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic        exec      [2];
  logic        we        [2];
  logic [7:0]  addr      [2];
  logic [15:0] wdata     [2];
  logic [15:0] odata     [2];
  logic        memReady  [2];
  logic        dataReady [2];
  logic        overrun   [2];

  logic [15:0] model [2][256];
  exp_t        sb0 [$];
  exp_t        sb1 [$];

  int edgeCount   = 0;
  int testsRun    = 0;
  int testsFailed = 0;

  mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WAIT_A)) dutA (
    .I_clk(clk), .I_reset_n(rstN), .I_execute(exec[0]), .I_we(we[0]),
    .I_addr(addr[0]), .I_data(wdata[0]), .O_data(odata[0]),
    .O_mem_ready(memReady[0]), .O_data_ready(dataReady[0]), .O_overrun(overrun[0])
  );

  mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WAIT_B)) dutB (
    .I_clk(clk), .I_reset_n(rstN), .I_execute(exec[1]), .I_we(we[1]),
    .I_addr(addr[1]), .I_data(wdata[1]), .O_data(odata[1]),
    .O_mem_ready(memReady[1]), .O_data_ready(dataReady[1]), .O_overrun(overrun[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCount <= edgeCount + 1;

  function automatic int waitOf(input int d);
    return (d == 0) ? WAIT_A : WAIT_B;
  endfunction

  function automatic void sbPush(input int d, input logic [15:0] data, input int edgeN);
    exp_t e;
    e.data    = data;
    e.edgeNum = edgeN;
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endfunction

  function automatic int sbSize(input int d);
    return (d == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic exp_t sbPop(input int d);
    if (d == 0) return sb0.pop_front();
    return sb1.pop_front();
  endfunction

  // Scoreboard monitor: every read completion must match the oldest
  // outstanding expectation in both data and completion edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (dataReady[d] === 1'b1) begin
        testsRun++;
        if (sbSize(d) == 0) begin
          testsFailed++;
          $display("[TB] FAIL spurious_data_ready dut%0d: pulse seen at edge %0d, required no pulse",
                   d, edgeCount);
        end else begin
          e = sbPop(d);
          if (odata[d] !== e.data) begin
            testsFailed++;
            $display("[TB] FAIL read_data dut%0d: got %h, required %h", d, odata[d], e.data);
          end
          testsRun++;
          if (edgeCount !== e.edgeNum) begin
            testsFailed++;
            $display("[TB] FAIL read_latency dut%0d: completed at edge %0d, required edge %0d",
                     d, edgeCount, e.edgeNum);
          end
        end
      end
    end
  end

  task automatic waitReady(input int d);
    int n;
    n = 0;
    while (memReady[d] !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (memReady[d] !== 1'b1) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL ready_timeout dut%0d: O_mem_ready=%b, required 1", d, memReady[d]);
    end
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while ((sbSize(d) != 0 || memReady[d] !== 1'b1) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sbSize(d) != 0 || memReady[d] !== 1'b1) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain_timeout dut%0d: %0d reads pending, ready=%b, required 0 and 1",
               d, sbSize(d), memReady[d]);
    end
  endtask

  // Issues one request at a negedge while ready; returns the accept edge.
  task automatic doRequest(input int d, input logic weV, input logic [7:0] addrV,
                           input logic [15:0] dataV, output int acceptEdge);
    waitReady(d);
    exec[d]    = 1'b1;
    we[d]      = weV;
    addr[d]    = addrV;
    wdata[d]   = dataV;
    acceptEdge = edgeCount + 1;
    if (weV) model[d][addrV] = dataV;
    else     sbPush(d, model[d][addrV], acceptEdge + waitOf(d) + 2);
    @(negedge clk);
    exec[d] = 1'b0;
    testsRun++;
    if (memReady[d] !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL ready_drop dut%0d: O_mem_ready=%b after accept, required 0", d, memReady[d]);
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    for (int d = 0; d < 2; d++) begin
      exec[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      testsRun++;
      if (odata[d] !== 16'h0000) begin
        testsFailed++; $display("[TB] FAIL reset_data dut%0d: got %h, required 0000", d, odata[d]);
      end
      testsRun++;
      if (memReady[d] !== 1'b0) begin
        testsFailed++; $display("[TB] FAIL reset_ready dut%0d: got %b, required 0", d, memReady[d]);
      end
      testsRun++;
      if (dataReady[d] !== 1'b0) begin
        testsFailed++; $display("[TB] FAIL reset_dready dut%0d: got %b, required 0", d, dataReady[d]);
      end
      testsRun++;
      if (overrun[d] !== 1'b0) begin
        testsFailed++; $display("[TB] FAIL reset_overrun dut%0d: got %b, required 0", d, overrun[d]);
      end
    end
    rstN = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      testsRun++;
      if (memReady[d] !== 1'b1) begin
        testsFailed++; $display("[TB] FAIL init_ready dut%0d: got %b, required 1", d, memReady[d]);
      end
      testsRun++;
      if (overrun[d] !== 1'b0) begin
        testsFailed++; $display("[TB] FAIL init_overrun dut%0d: got %b, required 0", d, overrun[d]);
      end
    end
  endtask

  task automatic test_write_read();
    int k;
    doRequest(0, 1'b1, 8'h05, 16'hBEEF, k);
    drain(0);
    testsRun++;
    if (odata[0] !== 16'h0000) begin
      testsFailed++; $display("[TB] FAIL data_hold_write: got %h, required 0000", odata[0]);
    end
    doRequest(0, 1'b0, 8'h05, 16'h0000, k);
    drain(0);
  endtask

  task automatic test_back_to_back();
    int k1, k2, k3, k4;
    doRequest(1, 1'b1, 8'h00, 16'h1234, k1);
    doRequest(1, 1'b1, 8'hFF, 16'h5678, k2);
    doRequest(1, 1'b0, 8'h00, 16'h0000, k3);
    doRequest(1, 1'b0, 8'hFF, 16'h0000, k4);
    testsRun++;
    if ((k2 - k1) !== WAIT_B + 3 || (k3 - k2) !== WAIT_B + 3 || (k4 - k3) !== WAIT_B + 3) begin
      testsFailed++;
      $display("[TB] FAIL throughput: accept spacing %0d/%0d/%0d, required %0d",
               k2 - k1, k3 - k2, k4 - k3, WAIT_B + 3);
    end
    drain(1);
    repeat (3) @(negedge clk);
    testsRun++;
    if (odata[1] !== 16'h5678) begin
      testsFailed++; $display("[TB] FAIL data_hold_b2b: got %h, required 5678", odata[1]);
    end
  endtask

  task automatic test_overrun();
    int k;
    waitReady(0);
    exec[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h03; wdata[0] = 16'hAAAA;
    model[0][8'h03] = 16'hAAAA;
    @(negedge clk);
    exec[0] = 1'b0;
    @(negedge clk);
    exec[0] = 1'b1; we[0] = 1'b0; addr[0] = 8'h09; wdata[0] = 16'h5555;
    @(negedge clk);
    exec[0] = 1'b0;
    testsRun++;
    if (overrun[0] !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL overrun_set: got %b, required 1", overrun[0]);
    end
    drain(0);
    repeat (4) @(negedge clk);
    doRequest(0, 1'b0, 8'h03, 16'h0000, k);
    drain(0);
    testsRun++;
    if (overrun[0] !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL overrun_sticky: got %b, required 1", overrun[0]);
    end
    testsRun++;
    if (overrun[1] !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL overrun_other: got %b, required 0", overrun[1]);
    end
  endtask

  task automatic test_async_reset();
    int k;
    doRequest(0, 1'b1, 8'h07, 16'h1111, k);
    drain(0);
    exec[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h07; wdata[0] = 16'hCCCC;
    @(negedge clk);
    exec[0] = 1'b0;
    #2 rstN = 1'b0;
    #1;
    testsRun++;
    if (memReady[0] !== 1'b0 || dataReady[0] !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL async_flags: ready=%b dready=%b, required 0 0", memReady[0], dataReady[0]);
    end
    testsRun++;
    if (odata[0] !== 16'h0000) begin
      testsFailed++; $display("[TB] FAIL async_data: got %h, required 0000", odata[0]);
    end
    testsRun++;
    if (overrun[0] !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL async_overrun: got %b, required 0", overrun[0]);
    end
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    doRequest(0, 1'b0, 8'h07, 16'h0000, k);
    drain(0);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_overrun();
    test_async_reset();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
